// File: rtl/sum_dsp_pkg.sv
// Shared constants and helpers for the sum-stream DSP chain (decimator, DAC feed).
package sum_dsp_pkg;
   localparam int SUM_W    = 15;
   localparam int OUT_W    = 14;
   localparam int MAX_LOG2 = 10;

   localparam logic signed [OUT_W-1:0] OUT_MAX = 14'sd8191;
   localparam logic signed [OUT_W-1:0] OUT_MIN = -14'sd8192;

   function automatic logic [3:0] clamp_log2(input logic [3:0] req);
      return (req > 4'(MAX_LOG2)) ? 4'(MAX_LOG2) : req;
   endfunction
endpackage

// File: rtl/sum_decimator_if.sv
// Sample-in / average-out bundle between the phase wrapper, decimator and readout.
interface sum_decimator_if;
   import sum_dsp_pkg::*;

   logic signed [SUM_W-1:0] sum_i;
   logic                    en_i;
   logic [3:0]              log2_decim_i;
   logic signed [OUT_W-1:0] data_o;
   logic                    valid_o;
   logic                    sat_o;
   logic                    busy_o;

   modport master (
      output sum_i, en_i, log2_decim_i,
      input  data_o, valid_o, sat_o, busy_o
   );

   modport slave (
      input  sum_i, en_i, log2_decim_i,
      output data_o, valid_o, sat_o, busy_o
   );
endinterface

// File: rtl/sum_decimator_sat_signed.sv
// Combinational signed saturator: clips IN_W-bit input to OUT_W bits and flags the clip.
module sat_signed #(
   parameter int IN_W  = 25,
   parameter int OUT_W = 14
) (
   input  logic signed [IN_W-1:0]  din,
   output logic signed [OUT_W-1:0] dout,
   output logic                    clip
);
   logic [IN_W-OUT_W:0] top;

   // In range exactly when every bit above the output sign bit repeats it.
   always_comb begin
      top  = din[IN_W-1:OUT_W-1];
      clip = !((&top) || !(|top));
      if (!clip)
         dout = din[OUT_W-1:0];
      else if (din[IN_W-1])
         dout = {1'b1, {(OUT_W-1){1'b0}}};
      else
         dout = {1'b0, {(OUT_W-1){1'b1}}};
   end
endmodule

// File: rtl/sum_decimator.sv
// Boxcar average over 2^k enabled samples with decimation, floor shift and saturation.
module sum_decimator
   import sum_dsp_pkg::*;
(
   input logic             clk_i,
   input logic             rst_i,
   sum_decimator_if.slave  bus
);
   localparam int ACC_W = SUM_W + MAX_LOG2;

   logic signed [ACC_W-1:0]    acc_p0;
   logic [MAX_LOG2-1:0]        count_p0;
   logic [3:0]                 shift_p0;
   logic signed [OUT_W-1:0]    data_p1;
   logic                       vld_p1;
   logic                       sat_p1;

   logic signed [ACC_W-1:0]    sum_ext;
   logic signed [ACC_W-1:0]    total;
   logic signed [ACC_W-1:0]    avg;
   logic [MAX_LOG2:0]          last_idx;
   logic                       last;
   logic signed [OUT_W-1:0]    avg_sat;
   logic                       clip;

   always_comb begin
      sum_ext  = {{MAX_LOG2{bus.sum_i[SUM_W-1]}}, bus.sum_i};
      total    = acc_p0 + sum_ext;
      avg      = total >>> shift_p0;
      last_idx = ((MAX_LOG2+1)'(1) << shift_p0) - (MAX_LOG2+1)'(1);
      last     = ({1'b0, count_p0} == last_idx);
   end

   sat_signed #(
      .IN_W  (ACC_W),
      .OUT_W (OUT_W)
   ) u_sat (
      .din  (avg),
      .dout (avg_sat),
      .clip (clip)
   );

   // Stage p0 -> p1: accumulate, and on the block's last sample register the average.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         acc_p0   <= '0;
         count_p0 <= '0;
         shift_p0 <= clamp_log2(bus.log2_decim_i);
         data_p1  <= '0;
         vld_p1   <= 1'b0;
         sat_p1   <= 1'b0;
      end else begin
         vld_p1 <= 1'b0;
         sat_p1 <= 1'b0;
         if (bus.en_i) begin
            if (last) begin
               acc_p0   <= '0;
               count_p0 <= '0;
               shift_p0 <= clamp_log2(bus.log2_decim_i);
               data_p1  <= avg_sat;
               vld_p1   <= 1'b1;
               sat_p1   <= clip;
            end else begin
               acc_p0   <= total;
               count_p0 <= count_p0 + MAX_LOG2'(1);
            end
         end
      end
   end

   assign bus.data_o  = data_p1;
   assign bus.valid_o = vld_p1;
   assign bus.sat_o   = sat_p1;
   assign bus.busy_o  = (count_p0 != '0);
endmodule

// File: tb/tb_sum_decimator.sv
// Directed and randomized check of sum_decimator against a block-average reference model.
module tb_sum_decimator;
   import sum_dsp_pkg::*;

   logic clk;
   logic rst_i;
   int   total_cnt = 0;
   int   bad_cnt   = 0;

   sum_decimator_if bus ();

   sum_decimator dut (
      .clk_i (clk),
      .rst_i (rst_i),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model state
   int   blk[$];
   int   m_len = 1;
   int   exp_data = 0;
   logic exp_valid = 1'b0;
   logic exp_sat = 1'b0;
   logic exp_busy = 1'b0;
   int   n_valid = 0;

   function automatic int clamp_m(input int l);
      return (l > MAX_LOG2) ? MAX_LOG2 : l;
   endfunction

   task automatic check(input string tag, input int obs, input int expv);
      total_cnt++;
      assert (obs === expv) else begin
         bad_cnt++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic cycle(input logic rst, input logic en, input int s, input int l2);
      int tot, q;
      rst_i            = rst;
      bus.en_i         = en;
      bus.sum_i        = SUM_W'(s);
      bus.log2_decim_i = 4'(l2);
      exp_valid = 1'b0;
      exp_sat   = 1'b0;
      if (rst) begin
         blk.delete();
         m_len    = 1 << clamp_m(l2);
         exp_data = 0;
      end else if (en) begin
         blk.push_back(s);
         if (blk.size() == m_len) begin
            tot = 0;
            foreach (blk[i]) tot += blk[i];
            q = tot / m_len;
            if ((tot % m_len != 0) && (tot < 0)) q--;
            if (q > 8191) begin exp_data = 8191; exp_sat = 1'b1; end
            else if (q < -8192) begin exp_data = -8192; exp_sat = 1'b1; end
            else exp_data = q;
            exp_valid = 1'b1;
            blk.delete();
            m_len = 1 << clamp_m(l2);
         end
      end
      exp_busy = (blk.size() != 0);
      @(posedge clk);
      #1;
      if (exp_valid) n_valid++;
      check("valid", int'(bus.valid_o), int'(exp_valid));
      check("sat",   int'(bus.sat_o),   int'(exp_sat));
      check("data",  int'(bus.data_o),  exp_data);
      check("busy",  int'(bus.busy_o),  int'(exp_busy));
   endtask

   initial begin
      int l2, v0;
      rst_i = 1'b1; bus.en_i = 1'b0; bus.sum_i = '0; bus.log2_decim_i = 4'd2;

      // constant 100, block of 4: three pulses
      cycle(1, 0, 0, 2);
      v0 = n_valid;
      for (int i = 0; i < 12; i++) cycle(0, 1, 100, 2);
      cycle(0, 0, 0, 2);
      check("pulses_const", n_valid - v0, 3);

      // floor rounding
      cycle(0, 1, -1, 2); cycle(0, 1, 0, 2); cycle(0, 1, 0, 2); cycle(0, 1, 0, 2);
      check("floor_neg", int'(bus.data_o), -1);
      cycle(0, 1, 1, 2); cycle(0, 1, 0, 2); cycle(0, 1, 0, 2); cycle(0, 1, 0, 2);
      check("floor_pos", int'(bus.data_o), 0);

      // saturation both ways, block of 8
      cycle(1, 0, 0, 3);
      for (int i = 0; i < 8; i++) cycle(0, 1, 10000, 3);
      check("sat_hi", int'(bus.data_o), 8191);
      for (int i = 0; i < 8; i++) cycle(0, 1, -12000, 3);
      check("sat_lo", int'(bus.data_o), -8192);

      // length change mid-block takes effect at boundary
      cycle(1, 0, 0, 1);
      v0 = n_valid;
      cycle(0, 1, 7, 1);
      cycle(0, 1, 9, 3);
      check("len2_out", int'(bus.valid_o), 1);
      for (int i = 0; i < 7; i++) cycle(0, 1, 50, 3);
      check("len8_wait", n_valid - v0, 1);
      cycle(0, 1, 50, 3);
      check("len8_out", n_valid - v0, 2);

      // gapped enables
      cycle(1, 0, 0, 2);
      v0 = n_valid;
      cycle(0, 1, 40, 2); cycle(0, 0, 999, 2); cycle(0, 1, 40, 2);
      cycle(0, 0, -999, 2); cycle(0, 1, 40, 2); cycle(0, 1, 40, 2);
      cycle(0, 0, 0, 2);
      check("gap_pulses", n_valid - v0, 1);

      // reset discards partial block
      v0 = n_valid;
      cycle(0, 1, 500, 2); cycle(0, 1, 500, 2);
      cycle(1, 0, 0, 2);
      for (int i = 0; i < 4; i++) cycle(0, 1, 20, 2);
      check("rst_pulses", n_valid - v0, 1);
      check("rst_data", int'(bus.data_o), 20);

      // shift 0 passthrough with continuous valid
      cycle(1, 0, 0, 0);
      for (int i = 0; i < 6; i++) cycle(0, 1, int'($urandom_range(0, 32767)) - 16384, 0);

      // randomized run
      l2 = 2;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 39) == 0) l2 = int'($urandom_range(0, 15));
         if ($urandom_range(0, 199) == 0)
            cycle(1, 0, 0, l2);
         else if ($urandom_range(0, 7) == 0)
            cycle(0, 1, ($urandom_range(0, 1) != 0) ? 16383 : -16384, l2);
         else
            cycle(0, ($urandom_range(0, 3) != 0), int'($urandom_range(0, 32767)) - 16384, l2);
      end

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end
endmodule
